hazard_div_ctrl: RTL and testbench
==================================

Name: hazard_div_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Drives StallF/StallD into the fetch and decode registers and FlushE into the decode-to-execute register.
- Sequences the multi-cycle HI/LO divider: start pulse, busy count, done/write-enable.
- Resolves three hazards: load-use, mfhi/mflo after div, and back-to-back div. Also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- DIV_CYCLES, 32, divider latency in cycles from DivStart to HiLoWE inclusive; legal range 2..255.
- CNT_W, 8, width of the internal divide countdown; must hold DIV_CYCLES-1.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous active-high reset
- RsD  input  5  decode source register s
- RtD  input  5  decode source register t
- divD  input  1  decode instruction is div
- mfD  input  2  decode HI/LO read: 00 none, 01 mfhi, 10 mflo, 11 illegal (treated as read)
- RtE  input  5  execute destination for loads
- MemtoRegE  input  1  execute instruction is a load
- RegWriteE  input  1  execute instruction writes the register file
- divE  input  1  execute instruction is div
- StallF  output  1  hold PC
- StallD  output  1  hold the fetch-to-decode register
- FlushE  output  1  bubble into the decode-to-execute register
- DivStart  output  1  one-cycle pulse; divider latches data1E/data2E this cycle
- DivBusy  output  1  divider occupied
- HiLoWE  output  1  one-cycle pulse; HI/LO written at the next edge
- StallCount  output  32  saturating count of cycles with StallD=1

Behaviour:
- FSM with two states, IDLE and BUSY, plus a CNT_W-bit countdown cnt.
- Reset state: IDLE, cnt=0, StallCount=0.
- Reset outputs: all outputs 0 in the cycle after reset is sampled high.
- Reset has priority over every event, including mid-division. A reset while BUSY abandons the divide with no HiLoWE.
- IDLE:
  - divE=1 -> DivStart=1 (combinational), next state BUSY, cnt<=DIV_CYCLES-1.
  - Otherwise stay in IDLE.
- BUSY:
  - DivBusy=1.
  - cnt>1 -> cnt<=cnt-1.
  - cnt==1 -> HiLoWE=1 (combinational), next state IDLE, cnt<=0.
- Total latency: DivStart in cycle T gives HiLoWE in cycle T+DIV_CYCLES-1. HI/LO is valid to readers from cycle T+DIV_CYCLES.
- divE arriving while BUSY cannot happen, because divD stalls (see below). The bench asserts this. RTL ignores it; no restart.
- Hazard terms (all combinational):
  - lwstall = MemtoRegE & RegWriteE & (RtE!=0) & (RtE==RsD | RtE==RtD)
  - mfstall = (mfD!=0) & (divE | state==BUSY)
  - divstall = divD & (divE | state==BUSY)
  - stall = lwstall | mfstall | divstall
- Outputs from stall: StallF = StallD = FlushE = stall.
- mfD or divD in decode during the HiLoWE cycle is still stalled, because state is BUSY. It is released the next cycle, with no bypass from the divider.
- Load-use stall lasts exactly one cycle: the bubble clears MemtoRegE.
- Simultaneous lwstall and mfstall: a single combined stall. Release happens when both clear.
- StallCount increments on each cycle with stall=1 and holds at 0xFFFFFFFF.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - mfD encodings MF_NONE, MF_HI, MF_LO;
  - FSM state encodings S_IDLE, S_BUSY;
  - default DIV_CYCLES.
- One natural sub-module, div_sequencer: FSM plus countdown, producing DivStart, DivBusy and HiLoWE.
- Hazard equations and StallCount stay in the top level.

Test Plan:
- Load-use: MemtoRegE=1, RegWriteE=1, RtE=8, RsD=8 -> stall=1 for exactly 1 cycle. With RtE=0 -> stall=0.
- Divide timing, DIV_CYCLES=4: divE=1 at cycle 10 -> DivStart at 10, DivBusy at 11-13, HiLoWE at 13 only, DivBusy=0 at 14.
- mfhi after div: divE at cycle 10, mfD=01 held in decode -> stall asserted cycles 10-13, released cycle 14. StallCount advances by 4.
- Back-to-back div: divE at 10, divD=1 -> stalled until 14. Second DivStart when that div reaches execute, never during BUSY.
- Reset mid-op: reset at cycle 12 of a DIV_CYCLES=4 divide -> cycle 13 shows state IDLE, all outputs 0, no HiLoWE, StallCount=0.
- Saturation: preload StallCount near 0xFFFFFFFF (forced), hold stall -> counter stays at 0xFFFFFFFF.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS pipeline control blocks.
package mips_ctrl_pkg;

    // Default divider latency, DivStart through HiLoWE inclusive
    localparam int unsigned DIV_CYCLES_DEF = 32;
    localparam int unsigned STALL_CNT_W    = 32;

    // HI/LO read encodings on mfD; 2'b11 is illegal and treated as a read
    localparam logic [1:0] MF_NONE = 2'b00;
    localparam logic [1:0] MF_HI   = 2'b01;
    localparam logic [1:0] MF_LO   = 2'b10;

    // Divider sequencer state encodings
    localparam logic S_IDLE = 1'b0;
    localparam logic S_BUSY = 1'b1;

    // Individual hazard terms feeding the combined stall
    typedef struct packed {
        logic lw;
        logic mf;
        logic div;
    } hazard_t;

endpackage

// File: rtl/hazard_div_ctrl_div_sequencer.sv
// Multi-cycle HI/LO divider sequencer: start pulse, busy countdown, write enable.
module div_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic divE,
    output logic DivStart,
    output logic DivBusy,
    output logic HiLoWE
);

    logic             state;
    logic             stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;

    // State and countdown registers; reset abandons any divide in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next-state and pulse decode; a divE seen while busy is ignored
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        DivStart  = 1'b0;
        DivBusy   = 1'b0;
        HiLoWE    = 1'b0;
        case (state)
            S_IDLE: begin
                if (divE) begin
                    DivStart  = 1'b1;
                    stateNext = S_BUSY;
                    cntNext   = CNT_W'(DIV_CYCLES - 1);
                end
            end
            S_BUSY: begin
                DivBusy = 1'b1;
                if (cnt > CNT_W'(1)) begin
                    cntNext = cnt - CNT_W'(1);
                end else begin
                    HiLoWE    = 1'b1;
                    stateNext = S_IDLE;
                    cntNext   = '0;
                end
            end
            default: begin
                stateNext = S_IDLE;
                cntNext   = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_div_ctrl.sv
// Pipeline hazard controller: load-use, HI/LO read after div, back-to-back div.
module hazard_div_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic        divD,
    input  logic [1:0]  mfD,
    input  logic [4:0]  RtE,
    input  logic        MemtoRegE,
    input  logic        RegWriteE,
    input  logic        divE,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic        DivStart,
    output logic        DivBusy,
    output logic        HiLoWE,
    output logic [31:0] StallCount
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

    hazard_t                hz;
    logic                   stall;
    logic [STALL_CNT_W-1:0] stallCnt;

    div_sequencer #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) uDivSeq (
        .clk      (clk),
        .reset    (reset),
        .divE     (divE),
        .DivStart (DivStart),
        .DivBusy  (DivBusy),
        .HiLoWE   (HiLoWE)
    );

    // Hazard detection; DivBusy stands in for the sequencer being in BUSY
    always_comb begin
        hz     = '0;
        hz.lw  = MemtoRegE & RegWriteE & (RtE != 5'd0) & ((RtE == RsD) | (RtE == RtD));
        hz.mf  = (mfD != MF_NONE) & (divE | DivBusy);
        hz.div = divD & (divE | DivBusy);
        stall  = hz.lw | hz.mf | hz.div;
    end

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

    // Saturating count of stalled decode cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt <= '0;
        end else if (stall && (stallCnt != CNT_MAX)) begin
            stallCnt <= stallCnt + STALL_CNT_W'(1);
        end
    end

    assign StallCount = stallCnt;

endmodule

// File: tb/tb_hazard_div_ctrl.sv
// Self-checking bench for hazard_div_ctrl against a timestamp-based reference model.
module tb_hazard_div_ctrl;
    import mips_ctrl_pkg::*;

    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  RsD, RtD, RtE;
    logic        divD, MemtoRegE, RegWriteE, divE;
    logic [1:0]  mfD;
    logic        StallF, StallD, FlushE, DivStart, DivBusy, HiLoWE;
    logic [31:0] StallCount;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          dsCyc    = -1000;   // cycle of the most recent accepted DivStart
    logic [31:0] expCnt   = '0;
    bit          chkOn    = 1'b0;

    always #5 clk = ~clk;

    hazard_div_ctrl #(.DIV_CYCLES(D), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .RsD        (RsD),
        .RtD        (RtD),
        .divD       (divD),
        .mfD        (mfD),
        .RtE        (RtE),
        .MemtoRegE  (MemtoRegE),
        .RegWriteE  (RegWriteE),
        .divE       (divE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushE     (FlushE),
        .DivStart   (DivStart),
        .DivBusy    (DivBusy),
        .HiLoWE     (HiLoWE),
        .StallCount (StallCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Divider is occupied in the DIV_CYCLES-1 cycles following DivStart
    function automatic bit mBusy();
        return (cyc > dsCyc) && (cyc <= dsCyc + int'(D) - 1);
    endfunction

    // One clock: drive at negedge, check mid-cycle, advance model at posedge
    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic dvD, input logic [1:0] mf, input logic [4:0] rte,
                        input logic m2r, input logic rw, input logic dvE);
        bit busy, eStart, eWE, lw, st;
        @(negedge clk);
        reset = rst; RsD = rs; RtD = rt; divD = dvD; mfD = mf;
        RtE = rte; MemtoRegE = m2r; RegWriteE = rw; divE = dvE;
        #2;
        busy   = mBusy();
        eStart = dvE && !busy;
        eWE    = busy && (cyc == dsCyc + int'(D) - 1);
        lw     = m2r && rw && (rte != 5'd0) && (rte == rs || rte == rt);
        st     = lw || ((mf != 2'b00) && (dvE || busy)) || (dvD && (dvE || busy));
        if (chkOn) begin
            chk("DivStart",   32'(DivStart), 32'(eStart));
            chk("DivBusy",    32'(DivBusy),  32'(busy));
            chk("HiLoWE",     32'(HiLoWE),   32'(eWE));
            chk("StallF",     32'(StallF),   32'(st));
            chk("StallD",     32'(StallD),   32'(st));
            chk("FlushE",     32'(FlushE),   32'(st));
            chk("StallCount", StallCount,    expCnt);
        end
        @(posedge clk);
        if (rst) begin
            dsCyc  = -1000;
            expCnt = '0;
        end else begin
            if (eStart) dsCyc = cyc;
            if (st && expCnt != 32'hFFFF_FFFF) expCnt = expCnt + 32'd1;
        end
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 1'b0, MF_NONE, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit          dv;
        logic [1:0]  mf;

        // Reset: first cycle unchecked (state unknown), then reset values
        step(1'b1, 5'd0, 5'd0, 1'b0, MF_NONE, 5'd0, 1'b0, 1'b0, 1'b0);
        chkOn = 1'b1;
        step(1'b1, 5'd0, 5'd0, 1'b0, MF_NONE, 5'd0, 1'b0, 1'b0, 1'b0);
        idle();

        // Load-use: one stall, then bubble clears MemtoRegE; RtE=0 never stalls
        step(1'b0, 5'd8, 5'd3, 1'b0, MF_NONE, 5'd8, 1'b1, 1'b1, 1'b0);
        step(1'b0, 5'd8, 5'd3, 1'b0, MF_NONE, 5'd8, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, MF_NONE, 5'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 5'd2, 5'd5, 1'b0, MF_NONE, 5'd5, 1'b1, 1'b1, 1'b0);
        idle();

        // Plain divide: start, three busy cycles, HiLoWE on the last, then idle
        step(1'b0, 5'd0, 5'd0, 1'b0, MF_NONE, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (4) idle();

        // mfhi held in decode behind a divide: 4 stalled cycles, then released
        step(1'b1, 5'd0, 5'd0, 1'b0, MF_NONE, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, MF_HI, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 5'd0, 5'd0, 1'b0, MF_HI, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, MF_HI, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("mf_stall_total", StallCount, 32'd4);
        idle();

        // Back-to-back div: second div held in decode, starts once it reaches execute
        step(1'b0, 5'd0, 5'd0, 1'b1, MF_NONE, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 5'd0, 5'd0, 1'b1, MF_NONE, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b1, MF_NONE, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, MF_NONE, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (4) idle();

        // Reset mid-divide: no HiLoWE afterwards, everything back to zero
        step(1'b0, 5'd0, 5'd0, 1'b0, MF_NONE, 5'd0, 1'b0, 1'b0, 1'b1);
        idle();
        step(1'b1, 5'd0, 5'd0, 1'b0, MF_LO, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_reset_HiLoWE",  32'(HiLoWE),  32'd0);
        chk("post_reset_DivBusy", 32'(DivBusy), 32'd0);
        chk("post_reset_count",   StallCount,   32'd0);
        repeat (3) idle();

        // Saturation: preload the counter just below all-ones and hold a load-use stall
        #1;
        force dut.stallCnt = 32'hFFFF_FFFD;
        #1;
        release dut.stallCnt;
        expCnt = 32'hFFFF_FFFD;
        repeat (5) step(1'b0, 5'd7, 5'd0, 1'b0, MF_NONE, 5'd7, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("saturated_count", StallCount, 32'hFFFF_FFFF);
        step(1'b1, 5'd0, 5'd0, 1'b0, MF_NONE, 5'd0, 1'b0, 1'b0, 1'b0);

        // Random traffic; divE never issued while the divider is occupied
        for (int i = 0; i < 400; i++) begin
            dv = !mBusy() && ($urandom_range(0, 3) == 0);
            mf = 2'($urandom_range(0, 3));
            step(1'b0 || ($urandom_range(0, 60) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 0) ? MF_NONE : mf,
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), dv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
